// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver for the MM:SS counter chain.
// Scans snapshot digits onto a common-anode display with blanking, LZB and a blinking colon.
module seg7_scan #(
  parameter logic [15:0] SCAN_DIV     = 16'd50000,
  parameter logic [15:0] BLANK_CYC    = 16'd500,
  parameter logic [7:0]  BLINK_FRAMES = 8'd125
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] SEC1,
  input  logic [2:0] SEC10,
  input  logic [3:0] MIN1,
  input  logic [2:0] MIN10,
  input  logic       LZB,
  input  logic       BLINK_EN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN,
  output logic       FRAME
);

  logic [15:0] r_pc;
  logic [1:0]  r_d;
  logic [3:0]  r_s [4];
  logic [7:0]  r_fc;
  logic        r_bp;
  logic [6:0]  r_seg;
  logic        r_dp;
  logic [3:0]  r_an;
  logic        r_frame;

  logic        w_slot_end;
  logic        w_snap;
  logic        w_blank;
  logic        w_dark;
  logic [3:0]  w_digit;
  logic [6:0]  w_decode;
  logic [6:0]  w_seg_next;
  logic        w_dp_next;
  logic [3:0]  w_an_next;
  logic [3:0]  w_cap [4];

  assign w_slot_end = (r_pc == SCAN_DIV - 16'd1);
  assign w_snap     = w_slot_end && (r_d == 2'd3);
  assign w_blank    = (r_pc < BLANK_CYC);
  assign w_digit    = r_s[r_d];

  assign w_cap[0] = SEC1;
  assign w_cap[1] = {1'b0, SEC10};
  assign w_cap[2] = MIN1;
  assign w_cap[3] = {1'b0, MIN10};

  // Only the current digit's anode is pulled low, and none during the blank window.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_an
      assign w_an_next[gi] = w_blank || (r_d != 2'(gi));
    end
  endgenerate

  always_comb begin
    w_decode = 7'b0111111;
    case (w_digit)
      4'd0: w_decode = 7'b1000000;
      4'd1: w_decode = 7'b1111001;
      4'd2: w_decode = 7'b0100100;
      4'd3: w_decode = 7'b0110000;
      4'd4: w_decode = 7'b0011001;
      4'd5: w_decode = 7'b0010010;
      4'd6: w_decode = 7'b0000010;
      4'd7: w_decode = 7'b1111000;
      4'd8: w_decode = 7'b0000000;
      4'd9: w_decode = 7'b0010000;
      default: w_decode = 7'b0111111;
    endcase
  end

  // A blanked leading zero still drives its anode so every digit has the same duty.
  assign w_dark     = LZB && (r_d == 2'd3) && (r_s[3] == 4'd0);
  assign w_seg_next = (w_blank || w_dark) ? 7'h7F : w_decode;
  assign w_dp_next  = !(!w_blank && (r_d == 2'd2) && BLINK_EN && r_bp);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pc    <= '0;
      r_d     <= '0;
      r_fc    <= '0;
      r_bp    <= 1'b0;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
      r_an    <= 4'hF;
      r_frame <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_s[i] <= '0;
      end
    end else begin
      r_pc <= w_slot_end ? 16'd0 : r_pc + 16'd1;
      if (w_slot_end) begin
        r_d <= r_d + 2'd1;
      end
      // Inputs are captured only at the frame boundary, so a frame never mixes two counts.
      if (w_snap) begin
        for (int i = 0; i < 4; i++) begin
          r_s[i] <= w_cap[i];
        end
        if (r_fc == BLINK_FRAMES - 8'd1) begin
          r_fc <= '0;
          r_bp <= !r_bp;
        end else begin
          r_fc <= r_fc + 8'd1;
        end
      end
      r_frame <= w_snap;
      r_seg   <= w_seg_next;
      r_dp    <= w_dp_next;
      r_an    <= w_an_next;
    end
  end

  assign SEG   = r_seg;
  assign DP    = r_dp;
  assign AN    = r_an;
  assign FRAME = r_frame;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: stimulus queues per-frame expectations,
// a monitor checks every cycle of each frame after its FRAME pulse.
module tb_seg7_scan;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] SEC1;
  logic [2:0] SEC10;
  logic [3:0] MIN1;
  logic [2:0] MIN10;
  logic       LZB;
  logic       BLINK_EN;
  logic [6:0] SEG;
  logic       DP;
  logic [3:0] AN;
  logic       FRAME;

  int checks = 0;
  int errors = 0;

  seg7_scan #(
    .SCAN_DIV    (16'd8),
    .BLANK_CYC   (16'd2),
    .BLINK_FRAMES(8'd2)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .SEC1    (SEC1),
    .SEC10   (SEC10),
    .MIN1    (MIN1),
    .MIN10   (MIN10),
    .LZB     (LZB),
    .BLINK_EN(BLINK_EN),
    .SEG     (SEG),
    .DP      (DP),
    .AN      (AN),
    .FRAME   (FRAME)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] sec1;
    logic [2:0] sec10;
    logic [3:0] min1;
    logic [2:0] min10;
    logic       lzb;
    logic       ben;
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] s2;
    logic [6:0] s3;
    logic       dp;
  } vec_t;

  vec_t vt [7];
  vec_t exp_q [$];

  function automatic vec_t mk(input logic [3:0] sec1, input logic [2:0] sec10,
                              input logic [3:0] min1, input logic [2:0] min10,
                              input logic lzb, input logic ben,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic dp);
    vec_t v;
    v.sec1 = sec1; v.sec10 = sec10; v.min1 = min1; v.min10 = min10;
    v.lzb = lzb; v.ben = ben;
    v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3; v.dp = dp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_frame();
    bit got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge CLK);
      if (FRAME) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout actual=no FRAME required=FRAME within 100 cycles");
    end
  endtask

  // Monitor: each FRAME pops the expectation for the 32 output cycles that follow.
  initial begin
    vec_t cur;
    bit   cur_valid = 0;
    int   idx = 0;
    int   fno = 0;
    forever begin
      @(negedge CLK);
      if (cur_valid && idx < 32 && !RESET) begin
        int slot;
        int pos;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        slot  = idx / 8;
        pos   = idx % 8;
        e_an  = (pos < 2) ? 4'hF : ~(4'b0001 << slot);
        case (slot)
          0: e_seg = cur.s0;
          1: e_seg = cur.s1;
          2: e_seg = cur.s2;
          default: e_seg = cur.s3;
        endcase
        if (pos < 2) e_seg = 7'h7F;
        e_dp = (pos >= 2 && slot == 2) ? cur.dp : 1'b1;
        chk($sformatf("frame%0d_cyc%0d", fno, idx), {20'd0, AN, SEG, DP}, {20'd0, e_an, e_seg, e_dp});
        idx++;
        if (idx == 32) $display("frame %0d checked (errors so far %0d)", fno, errors);
      end
      if (FRAME) begin
        fno++;
        idx = 0;
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          cur_valid = 1;
        end else begin
          cur_valid = 0;
        end
      end
    end
  end

  initial begin
    vt[0] = mk(4'd2,  3'd3, 4'd4, 3'd5, 1'b0, 1'b1, 7'h24, 7'h30, 7'h19, 7'h12, 1'b1);
    vt[1] = mk(4'd7,  3'd3, 4'd4, 3'd5, 1'b0, 1'b1, 7'h78, 7'h30, 7'h19, 7'h12, 1'b0);
    vt[2] = mk(4'd7,  3'd3, 4'd4, 3'd0, 1'b1, 1'b1, 7'h78, 7'h30, 7'h19, 7'h7F, 1'b0);
    vt[3] = mk(4'd7,  3'd3, 4'd4, 3'd0, 1'b0, 1'b1, 7'h78, 7'h30, 7'h19, 7'h40, 1'b1);
    vt[4] = mk(4'd12, 3'd3, 4'd4, 3'd0, 1'b0, 1'b1, 7'h3F, 7'h30, 7'h19, 7'h40, 1'b1);
    vt[5] = mk(4'd12, 3'd5, 4'd9, 3'd0, 1'b0, 1'b0, 7'h3F, 7'h12, 7'h10, 7'h40, 1'b1);
    vt[6] = mk(4'd0,  3'd1, 4'd8, 3'd5, 1'b1, 1'b1, 7'h40, 7'h79, 7'h00, 7'h12, 1'b0);

    RESET = 1'b1;
    SEC1 = 4'd0; SEC10 = 3'd0; MIN1 = 4'd0; MIN10 = 3'd0;
    LZB = 1'b0; BLINK_EN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_state", {20'd0, AN, SEG, DP, FRAME}, {20'd0, 4'hF, 7'h7F, 1'b1, 1'b0});

    SEC1 = vt[0].sec1; SEC10 = vt[0].sec10; MIN1 = vt[0].min1; MIN10 = vt[0].min10;
    exp_q.push_back(vt[0]);
    RESET = 1'b0;

    for (int n = 1; n <= 32; n++) begin
      @(negedge CLK);
      if (n == 4)  chk("first_frame_slot0", {25'd0, AN, SEG}, {25'd0, 4'b1110, 7'h40});
      if (n == 31) chk("no_early_frame", {31'd0, FRAME}, 32'd0);
      if (n == 32) chk("first_frame_pulse", {31'd0, FRAME}, 32'd1);
    end
    $display("first snapshot after release, inputs %0d%0d:%0d%0d", vt[0].min10, vt[0].min1, vt[0].sec10, vt[0].sec1);

    for (int i = 0; i < 7; i++) begin
      if (i > 0) wait_frame();
      LZB = vt[i].lzb;
      BLINK_EN = vt[i].ben;
      if (i < 6) begin
        repeat (10) @(negedge CLK);
        SEC1 = vt[i+1].sec1; SEC10 = vt[i+1].sec10;
        MIN1 = vt[i+1].min1; MIN10 = vt[i+1].min10;
        exp_q.push_back(vt[i+1]);
        $display("vector %0d queued: %0d%0d:%0d%0d lzb=%0b blink=%0b", i + 1,
                 vt[i+1].min10, vt[i+1].min1, vt[i+1].sec10, vt[i+1].sec1, vt[i+1].lzb, vt[i+1].ben);
      end
    end
    wait_frame();

    repeat (20) @(negedge CLK);
    chk("pre_reset_slot2_lit", {28'd0, AN}, {28'd0, 4'b1011});
    #1 RESET = 1'b1;
    #1 chk("async_reset_outputs", {20'd0, AN, SEG, DP, FRAME}, {20'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("restart_blank", {25'd0, AN, SEG}, {25'd0, 4'hF, 7'h7F});
    repeat (2) @(negedge CLK);
    chk("restart_slot0_zero", {24'd0, AN, SEG, DP}, {24'd0, 4'b1110, 7'h40, 1'b1});
    $display("reset restart observed");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
